// File: rtl/gs_div_pkg.sv
// Shared types and fixed-point constants for the Goldschmidt divider.
// GS_DIV_EXACT_EN (see gs_divider_seq) enables the final correction state.
package gs_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_CORR,
        S_DONE
    } state_t;

    // Fraction bits of the internal N/D/F fixed-point format.
    function automatic int int_frac_bits(input int width, input int frac, input int guard);
        return 2 * width + frac + guard;
    endfunction

    // 2.0 with fb fraction bits.
    function automatic logic [63:0] fx_two(input int fb);
        return 64'd2 << fb;
    endfunction

    // 2.9375 with fb fraction bits: F0 = 2.9375 - 2*D is a linear 1/D seed on [0.5,1).
    function automatic logic [63:0] fx_seed(input int fb);
        return 64'd47 << (fb - 4);
    endfunction

endpackage

// File: rtl/gs_lzc.sv
// Parametrised leading-zero counter; returns WIDTH for an all-zero input.
module gs_lzc #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    output logic [CW-1:0]    cnt
);

    // NOTE: default assignment first so no path through the loop leaves cnt unassigned (no latch).
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) cnt = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/gs_divider_seq.sv
// Sequential Goldschmidt divider: q = x * 2^FRAC / y with valid/ready handshakes.
// Define GS_DIV_EXACT_EN to add the CORR state that makes q exactly floor().
module gs_divider_seq
    import gs_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 8,
    parameter int ITER  = 3,
    parameter int GUARD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      x,
    input  logic [WIDTH-1:0]      y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH+FRAC-1:0] q,
    output logic                  dbz,
    output logic                  busy
);

    localparam int FB = int_frac_bits(WIDTH, FRAC, GUARD);
    localparam int NW = WIDTH + 1 + FB;   // N: quotient estimate, can briefly exceed x/y
    localparam int DW = FB + 1;           // D: one integer bit, the seed may overshoot 1.0
    localparam int FW = FB + 2;           // F: below 2.0
    localparam int QW = WIDTH + FRAC;
    localparam int LW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] TWO  = FW'(fx_two(FB));
    localparam logic [FW-1:0] SEED = FW'(fx_seed(FB));

    state_t             state;
    logic [WIDTH-1:0]   x_r, y_r;
    logic [NW-1:0]      n_r;
    logic [DW-1:0]      d_r;
    logic [2:0]         it_cnt;

    logic [LW-1:0]      lz;
    logic [2*WIDTH-1:0] x_sh;
    logic [WIDTH-1:0]   y_sh;
    logic [NW-1:0]      n_init, n_op, n_next;
    logic [DW-1:0]      d_init, d_op, d_next;
    logic [FW-1:0]      f_cur;
    logic [NW+FW-1:0]   n_prod;
    logic [DW+FW-1:0]   d_prod;
    logic [QW-1:0]      q_est;

    gs_lzc #(.WIDTH(WIDTH), .CW(LW)) u_lzc (
        .a   (y_r),
        .cnt (lz)
    );

    // Normalise y so D lies in [0.5,1); N takes the same shift so N/D == x/y.
    assign x_sh   = {{WIDTH{1'b0}}, x_r} << lz;
    assign y_sh   = y_r << lz;
    assign n_init = NW'(x_sh) << (FB - WIDTH);
    assign d_init = DW'(y_sh) << (FB - WIDTH);

    // NORM applies the linear seed through the same multipliers, so ITER passes of 2-D suffice.
    assign n_op   = (state == S_NORM) ? n_init : n_r;
    assign d_op   = (state == S_NORM) ? d_init : d_r;
    assign f_cur  = (state == S_NORM) ? SEED - {d_op, 1'b0} : TWO - {1'b0, d_op};
    assign n_prod = {{FW{1'b0}}, n_op} * {{NW{1'b0}}, f_cur};
    assign d_prod = {{FW{1'b0}}, d_op} * {{DW{1'b0}}, f_cur};
    assign n_next = NW'(n_prod >> FB);
    assign d_next = DW'(d_prod >> FB);
    assign q_est  = QW'(n_next >> (FB - FRAC));

`ifdef GS_DIV_EXACT_EN
    localparam int RW = 2 * WIDTH + FRAC + 1;
    logic [RW-1:0] num_ext, qy, r;
    logic          r_neg, r_ge;

    assign num_ext = RW'({x_r, {FRAC{1'b0}}});
    assign qy      = RW'(q) * RW'(y_r);
    assign r       = num_ext - qy;
    assign r_neg   = r[RW-1];
    assign r_ge    = !r_neg && (r >= RW'(y_r));
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // NOTE: datapath registers share the async reset with the FSM; an aborted division leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            dbz       <= 1'b0;
            q         <= '0;
            x_r       <= '0;
            y_r       <= '0;
            n_r       <= '0;
            d_r       <= '0;
            it_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r      <= x;
                        y_r      <= y;
                        dbz      <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (y_r == '0) begin
                        q         <= '1;
                        dbz       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        n_r    <= n_next;
                        d_r    <= d_next;
                        it_cnt <= '0;
                        state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    n_r    <= n_next;
                    d_r    <= d_next;
                    it_cnt <= it_cnt + 3'd1;
                    if (it_cnt == 3'(ITER - 1)) begin
                        q <= q_est;
`ifdef GS_DIV_EXACT_EN
                        state <= S_CORR;
`else
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`endif
                    end
                end
`ifdef GS_DIV_EXACT_EN
                S_CORR: begin
                    if (r_neg)     q <= q - QW'(1);
                    else if (r_ge) q <= q + QW'(1);
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_divider_seq.sv
// Self-checking bench for gs_divider_seq at default parameters, exact or raw build.
module tb_gs_divider_seq;

`ifdef GS_DIV_EXACT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x, y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        dbz;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    gs_divider_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .dbz       (dbz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact build must match floor(); raw build may be off by one ulp. y=0 is exact in both.
    task automatic check_q(input string tag, input logic [15:0] got, input logic [7:0] a, input logic [7:0] b);
        int exp;
        int err;
        exp = (b == 8'd0) ? 32'hFFFF : (int'(a) * 256) / int'(b);
`ifdef GS_DIV_EXACT_EN
        check(tag, 32'(got), 32'(exp));
`else
        if (b == 8'd0) begin
            check(tag, 32'(got), 32'(exp));
        end else begin
            err = int'(got) - exp;
            if (err < -1 || err > 1)
                $display("FAIL %s: got 0x%0h expected 0x%0h +/-1", tag, got, exp);
            n_cmp++;
            if (err < -1 || err > 1) n_err++;
        end
`endif
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_before_launch", 32'(in_ready), 32'd1);
        x = a;
        y = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] rq, output logic rdbz, output int lat);
        launch(a, b);
        wait_valid(lat);
        rq   = q;
        rdbz = dbz;
        release_out();
    endtask

    initial begin
        logic [15:0] rq;
        logic        rdbz;
        int          lat;
        int          seen;
        logic [7:0]  a, b;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run(8'h34, 8'h30, rq, rdbz, lat);
        check_q("q_34_30", rq, 8'h34, 8'h30);
`ifdef GS_DIV_EXACT_EN
        check("q_34_30_exact", 32'(rq), 32'h0115);
`endif
        check("dbz_34_30", 32'(rdbz), 32'd0);
        check("lat_34_30", 32'(lat), 32'(LAT));
        check("idle_after_handshake", 32'(in_ready), 32'd1);

        run(8'hFF, 8'h01, rq, rdbz, lat);
        check_q("q_ff_01", rq, 8'hFF, 8'h01);
        run(8'h01, 8'hFF, rq, rdbz, lat);
        check_q("q_01_ff", rq, 8'h01, 8'hFF);
        check("lat_01_ff", 32'(lat), 32'(LAT));

        run(8'h00, 8'h05, rq, rdbz, lat);
        check("q_00_05", 32'(rq), 32'd0);
        check("dbz_00_05", 32'(rdbz), 32'd0);

        run(8'h12, 8'h00, rq, rdbz, lat);
        check("q_12_00", 32'(rq), 32'hFFFF);
        check("dbz_12_00", 32'(rdbz), 32'd1);
        check("lat_12_00", 32'(lat), 32'd1);

        // Consumer stalls 10 cycles while other operand pairs are offered.
        launch(8'h34, 8'h30);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(1, 255));
            in_valid = i[0];
            @(posedge clk); #1;
            check_q("stall_q", q, 8'h34, 8'h30);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_dbz", 32'(dbz), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        check("stall_release_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_no_capture_busy", 32'(busy), 32'd0);

        // Reset while iterating aborts the division.
        launch(8'h34, 8'h30);
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_q", 32'(q), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mid_no_stale", 32'(seen), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        run(8'h34, 8'h30, rq, rdbz, lat);
        check_q("mid_next_q", rq, 8'h34, 8'h30);
        check("mid_next_lat", 32'(lat), 32'(LAT));

        // Full divisor sweep for two dividends, then random pairs.
        for (int j = 0; j < 256; j++) begin
            for (int k = 0; k < 2; k++) begin
                a = (k == 0) ? 8'hFF : 8'hA7;
                b = 8'(j);
                run(a, b, rq, rdbz, lat);
                check_q($sformatf("sweep_q x=%0h y=%0h", a, b), rq, a, b);
                check($sformatf("sweep_dbz x=%0h y=%0h", a, b), 32'(rdbz), 32'(b == 8'd0));
            end
        end
        for (int j = 0; j < 300; j++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run(a, b, rq, rdbz, lat);
            check_q($sformatf("rand_q x=%0h y=%0h", a, b), rq, a, b);
            check($sformatf("rand_lat x=%0h y=%0h", a, b), 32'(lat), (b == 8'd0) ? 32'd1 : 32'(LAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
